// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: groups the ID/EX hazard inputs and the pipeline control outputs
// of pipeline_ctrl.
//   master : pipeline side; drives the decoded ID/EX fields and receives the controls
//   slave  : pipeline_ctrl; reads the ID/EX fields and drives the controls
// Signals:
//   id_rs1/id_rs2 [4:0], id_uses_rs2, id_branch, id_jump, branch_taken : ID stage
//   ex_valid, ex_mem_read, ex_rd [4:0], ex_alu_op [1:0]                 : EX stage
//   pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble     : controls
//   stall_cnt [15:0]                                                    : stalled-cycle count
interface pipeline_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic        id_branch;
    logic        id_jump;
    logic        branch_taken;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_alu_op;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_bubble;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, id_branch, id_jump, branch_taken,
        output ex_valid, ex_mem_read, ex_rd, ex_alu_op,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, id_branch, id_jump, branch_taken,
        input  ex_valid, ex_mem_read, ex_rd, ex_alu_op,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall/flush controller for a 5-stage in-order pipeline.
// Detects load-use hazards, holds the pipeline for multi-cycle multiplies and flushes
// IF/ID on taken branches and jumps. Counts stalled cycles in a saturating counter.
// Ports:
//   clk     : rising-edge clock
//   arst_n  : asynchronous active-low reset
//   ctrl_io : pipeline_ctrl_if.slave (ID/EX fields in, pipeline controls out)
// Parameters:
//   MUL_CYCLES : EX-stage occupancy of a multiply, legal range 2..16
// Configuration:
//   PIPE_MUL_MULTICYCLE_EN : when defined, multiplies occupy EX for MUL_CYCLES cycles
//   (MUL_BUSY path). Undefined: multiplies are single-cycle, FSM stays in RUN and
//   ex_mem_bubble is constant 0.
module pipeline_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic           clk,
    input  logic           arst_n,
    pipeline_ctrl_if.slave ctrl_io
);

    typedef enum logic [0:0] {StRun, StMulBusy} state_e;

    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q;

    logic load_use;
    logic lu_stall;
    logic mul_start;
    logic mul_stall;
    logic redirect;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_bubble;

    assign load_use = ctrl_io.ex_valid && ctrl_io.ex_mem_read && (ctrl_io.ex_rd != 5'd0) &&
                      ((ctrl_io.ex_rd == ctrl_io.id_rs1) ||
                       (ctrl_io.id_uses_rs2 && (ctrl_io.ex_rd == ctrl_io.id_rs2)));

`ifdef PIPE_MUL_MULTICYCLE_EN
    assign mul_start = (state_q == StRun) && ctrl_io.ex_valid && (ctrl_io.ex_alu_op == 2'b11);
    // Stall on the start cycle and while more than one busy cycle remains; the cnt==1
    // cycle lets the pipeline advance, giving MUL_CYCLES-1 stalled cycles in total.
    assign mul_stall = mul_start || ((state_q == StMulBusy) && (cnt_q > 4'd1));
`else
    assign mul_start = 1'b0;
    assign mul_stall = 1'b0;
    logic unused_alu_op;
    assign unused_alu_op = ^ctrl_io.ex_alu_op;
`endif

    // A load-use seen while a multiply is in flight is not acted on; the hold keeps ID
    // intact, so it is picked up again once the FSM is back in RUN.
    assign lu_stall = load_use && (state_q == StRun) && !mul_stall;
    assign redirect = ctrl_io.id_jump || (ctrl_io.id_branch && ctrl_io.branch_taken);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (mul_start) begin
                    state_d = StMulBusy;
                    cnt_d   = MulLoad;
                end
            end
            StMulBusy: begin
                cnt_d = cnt_q - 4'd1;
                // <= guards against a stuck FSM should cnt ever read 0 here
                if (cnt_q <= 4'd1) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are combinational; reset forces the free-running defaults so a hazard
    // pattern on the inputs cannot leak out while arst_n is low.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if (!arst_n) begin
            pc_write = 1'b1;
        end else if (mul_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (lu_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign ctrl_io.pc_write      = pc_write;
    assign ctrl_io.if_id_write   = if_id_write;
    assign ctrl_io.if_id_flush   = if_id_flush;
    assign ctrl_io.id_ex_bubble  = id_ex_bubble;
    assign ctrl_io.ex_mem_bubble = ex_mem_bubble;
    assign ctrl_io.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector scoreboard bench for pipeline_ctrl.
// Each vector is driven just after a rising edge and its expected controls are queued;
// a monitor pops and compares on every falling edge while the queue is non-empty.
// Expected control vector bits: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
// ex_mem_bubble}. Expectations adapt to PIPE_MUL_MULTICYCLE_EN.
module tb_pipeline_ctrl;

    localparam int unsigned MulCycles = 4;
    localparam logic [4:0] ERun = 5'b11000;
    localparam logic [4:0] ELu  = 5'b00010;
    localparam logic [4:0] EMul = 5'b00001;
    localparam logic [4:0] EFl  = 5'b11100;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.MUL_CYCLES(MulCycles)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .ctrl_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses2;
        logic       br;
        logic       jmp;
        logic       taken;
        logic       exv;
        logic       mrd;
        logic [4:0] rd;
        logic [1:0] op;
    } in_t;

    typedef struct {
        string       name;
        logic [4:0]  bits;
        logic [15:0] scnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_scnt = 16'd0;
    logic [4:0]  e_mul;

    exp_t        m_e;
    logic [4:0]  m_obs;

    function automatic in_t nop();
        in_t v;
        v.rst_n = 1'b1;
        v.rs1   = 5'd1;
        v.rs2   = 5'd2;
        v.uses2 = 1'b0;
        v.br    = 1'b0;
        v.jmp   = 1'b0;
        v.taken = 1'b0;
        v.exv   = 1'b1;
        v.mrd   = 1'b0;
        v.rd    = 5'd9;
        v.op    = 2'b00;
        return v;
    endfunction

    task automatic drive(input in_t v);
        arst_n           = v.rst_n;
        bus.id_rs1       = v.rs1;
        bus.id_rs2       = v.rs2;
        bus.id_uses_rs2  = v.uses2;
        bus.id_branch    = v.br;
        bus.id_jump      = v.jmp;
        bus.branch_taken = v.taken;
        bus.ex_valid     = v.exv;
        bus.ex_mem_read  = v.mrd;
        bus.ex_rd        = v.rd;
        bus.ex_alu_op    = v.op;
    endtask

    // One clock of stimulus; stall_cnt seen this cycle reflects stalls of earlier cycles.
    task automatic cyc(input string name, input in_t v, input logic [4:0] eb);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        if (!v.rst_n) exp_scnt = 16'd0;
        e.name = name;
        e.bits = eb;
        e.scnt = exp_scnt;
        sb_q.push_back(e);
        if (v.rst_n && !eb[4] && (exp_scnt != 16'hFFFF)) exp_scnt = exp_scnt + 16'd1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                m_e   = sb_q.pop_front();
                m_obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                         bus.id_ex_bubble, bus.ex_mem_bubble};
                n_cmp++;
                if (m_obs !== m_e.bits) begin
                    n_bad++;
                    $display("FAIL %s ctrl: got %b expected %b", m_e.name, m_obs, m_e.bits);
                end
                n_cmp++;
                if (bus.stall_cnt !== m_e.scnt) begin
                    n_bad++;
                    $display("FAIL %s stall_cnt: got %0d expected %0d", m_e.name,
                             bus.stall_cnt, m_e.scnt);
                end
            end
        end
    end

    initial begin
        in_t v;
        in_t mul;
`ifdef PIPE_MUL_MULTICYCLE_EN
        e_mul = EMul;
`else
        e_mul = ERun;
`endif
        v = nop();
        v.rst_n = 1'b0;
        drive(v);
        mul     = nop();
        mul.op  = 2'b11;

        // Reset with a hazard and a jump present: outputs must still be the idle values.
        v = nop(); v.rst_n = 1'b0; v.mrd = 1'b1; v.rd = 5'd1; v.jmp = 1'b1;
        cyc("reset_hold", v, ERun);
        cyc("release", nop(), ERun);

        // Load-use on rs1, then clears after one cycle
        v = nop(); v.mrd = 1'b1; v.rd = 5'd5; v.rs1 = 5'd5;
        cyc("lu_x5", v, ELu);
        cyc("lu_x5_after", nop(), ERun);
        v = nop(); v.mrd = 1'b1; v.rd = 5'd0; v.rs1 = 5'd0;
        cyc("lu_x0", v, ERun);
        v = nop(); v.mrd = 1'b1; v.rd = 5'd7; v.rs2 = 5'd7; v.uses2 = 1'b1;
        cyc("lu_rs2", v, ELu);
        v.uses2 = 1'b0;
        cyc("lu_rs2_unused", v, ERun);
        v = nop(); v.exv = 1'b0; v.mrd = 1'b1; v.rd = 5'd1;
        cyc("lu_bubble", v, ERun);

        // Stall suppresses flush; flush fires once the stall clears
        v = nop(); v.mrd = 1'b1; v.rd = 5'd3; v.rs1 = 5'd3; v.br = 1'b1; v.taken = 1'b1;
        cyc("br_in_stall", v, ELu);
        v = nop(); v.br = 1'b1; v.taken = 1'b1;
        cyc("br_taken", v, EFl);
        v = nop(); v.jmp = 1'b1;
        cyc("jump", v, EFl);
        v = nop(); v.br = 1'b1;
        cyc("br_not_taken", v, ERun);

        // Multiply: MUL_CYCLES-1 stalled cycles, counter cleared first
        v = nop(); v.rst_n = 1'b0;
        cyc("rst_pre_mul", v, ERun);
        cyc("mul0", mul, e_mul);
        cyc("mul1", mul, e_mul);
        cyc("mul2", mul, e_mul);
        cyc("mul3", mul, ERun);
        cyc("mul_done", nop(), ERun);

`ifdef PIPE_MUL_MULTICYCLE_EN
        // Load-use and jump during MUL_BUSY add nothing; load-use acts once back in RUN
        cyc("mlu0", mul, EMul);
        v = mul; v.mrd = 1'b1; v.rd = 5'd6; v.rs1 = 5'd6; v.jmp = 1'b1;
        cyc("mlu1", v, EMul);
        cyc("mlu2", v, EMul);
        v.jmp = 1'b0;
        cyc("mlu3", v, ERun);
        v.op = 2'b00;
        cyc("mlu_run", v, ELu);
        cyc("mlu_done", nop(), ERun);
`endif

        // Reset in the middle of MUL_BUSY (cnt==2), then a full multiply from RUN
        v = nop(); v.rst_n = 1'b0;
        cyc("mr0", mul, e_mul);
        cyc("mr1", mul, e_mul);
        v = mul; v.rst_n = 1'b0;
        cyc("mr_reset", v, ERun);
        cyc("mr_release", nop(), ERun);
        cyc("mr_m0", mul, e_mul);
        cyc("mr_m1", mul, e_mul);
        cyc("mr_m2", mul, e_mul);
        cyc("mr_m3", mul, ERun);
        cyc("mr_done", nop(), ERun);

        // Saturation: hold a load-use hazard for well over 65535 cycles
        v = nop(); v.mrd = 1'b1; v.rd = 5'd4; v.rs1 = 5'd4;
        cyc("sat_start", v, ELu);
        repeat (65540) @(posedge clk);
        exp_scnt = 16'hFFFF;
        cyc("sat_hold0", v, ELu);
        cyc("sat_hold1", v, ELu);
        cyc("sat_release", nop(), ERun);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
